// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - RAW hazard stall/flush controller with cycle-exact halt drain FSM
//
// Purpose:
//   Tracks register writes in flight in EX and MEM with a two-slot scoreboard.
//   Detects RAW hazards against the instruction in ID and drives stall, bubble
//   and flush controls. A halt word in ID starts a fixed-length drain, after
//   which the pipeline is frozen with halt_done asserted until reset.
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   Defined   -> saturating stall/flush performance counters.
//   Undefined -> stall_cnt/flush_cnt tied to 0, no counter flops.
//
// Ports:
//   CLK, RST_N        clock, asynchronous active-low reset
//   instr_valid_d     ID holds a real instruction
//   rs_addr_d/rt_addr_d, uses_rs_d/uses_rt_d   ID source operands and their use
//   dst_addr_d, reg_write_d                    ID destination and write enable
//   halt_d            ID instruction is the halt word
//   redirect_m        taken branch/jump resolved in MEM
//   stall_f, stall_d, bubble_e, flush          pipeline controls
//   halt_done         pipeline drained after halt (sticky)
//   state             RUN=00, DRAIN=01, HALTED=10
//   stall_cnt, flush_cnt                       performance counters
module hazard_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             instr_valid_d,
    input  logic [4:0]       rs_addr_d,
    input  logic [4:0]       rt_addr_d,
    input  logic             uses_rs_d,
    input  logic             uses_rt_d,
    input  logic [4:0]       dst_addr_d,
    input  logic             reg_write_d,
    input  logic             halt_d,
    input  logic             redirect_m,
    output logic             stall_f,
    output logic             stall_d,
    output logic             bubble_e,
    output logic             flush,
    output logic             halt_done,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] ST_RUN    = 2'b00;
    localparam logic [1:0] ST_DRAIN  = 2'b01;
    localparam logic [1:0] ST_HALTED = 2'b10;

    logic       ex_v_q,   ex_v_d;
    logic [4:0] ex_addr_q, ex_addr_d;
    logic       mem_v_q,  mem_v_d;
    logic [4:0] mem_addr_q, mem_addr_d;
    logic [1:0] state_q,  state_d;
    logic [3:0] drain_cnt_q, drain_cnt_d;

    logic rs_hit, rt_hit, raw;
    logic hold, flush_c, raw_stall;

    // Register $0 never carries a dependency, so operand 0 never matches.
    always_comb begin
        rs_hit = (rs_addr_d != 5'd0) &&
                 ((ex_v_q && ex_addr_q == rs_addr_d) || (mem_v_q && mem_addr_q == rs_addr_d));
        rt_hit = (rt_addr_d != 5'd0) &&
                 ((ex_v_q && ex_addr_q == rt_addr_d) || (mem_v_q && mem_addr_q == rt_addr_d));
        raw    = instr_valid_d && ((uses_rs_d && rs_hit) || (uses_rt_d && rt_hit));
    end

    always_comb begin
        hold        = 1'b0;
        flush_c     = 1'b0;
        raw_stall   = 1'b0;
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            ST_RUN: begin
                // Flush outranks a hazard stall: the stalled instruction is wrong-path.
                flush_c   = redirect_m;
                raw_stall = raw && !redirect_m;
                hold      = raw_stall;
                if (halt_d && instr_valid_d && !raw && !redirect_m) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = 4'(DRAIN_CYCLES - 1);
                end
            end
            ST_DRAIN: begin
                hold    = 1'b1;
                flush_c = redirect_m;
                if (redirect_m) begin
                    // Halt was fetched down a mispredicted path; resume.
                    state_d     = ST_RUN;
                    drain_cnt_d = 4'd0;
                end else if (drain_cnt_q == 4'd0) begin
                    state_d = ST_HALTED;
                end else begin
                    drain_cnt_d = drain_cnt_q - 4'd1;
                end
            end
            ST_HALTED: begin
                hold = 1'b1;
            end
            default: begin
                state_d     = ST_RUN;
                drain_cnt_d = 4'd0;
            end
        endcase
    end

    always_comb begin
        if (flush_c) begin
            mem_v_d    = 1'b0;
            mem_addr_d = ex_addr_q;
            ex_v_d     = 1'b0;
            ex_addr_d  = dst_addr_d;
        end else begin
            mem_v_d    = ex_v_q;
            mem_addr_d = ex_addr_q;
            ex_v_d     = instr_valid_d && reg_write_d && (dst_addr_d != 5'd0) && !hold;
            ex_addr_d  = dst_addr_d;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ex_v_q      <= 1'b0;
            ex_addr_q   <= 5'd0;
            mem_v_q     <= 1'b0;
            mem_addr_q  <= 5'd0;
            state_q     <= ST_RUN;
            drain_cnt_q <= 4'd0;
        end else begin
            ex_v_q      <= ex_v_d;
            ex_addr_q   <= ex_addr_d;
            mem_v_q     <= mem_v_d;
            mem_addr_q  <= mem_addr_d;
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    assign stall_f   = hold;
    assign stall_d   = hold;
    assign bubble_e  = hold;
    assign flush     = flush_c;
    assign halt_done = (state_q == ST_HALTED);
    assign state     = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (raw_stall && stall_cnt_q != {CNT_W{1'b1}})
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush_c && flush_cnt_q != {CNT_W{1'b1}})
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl against a behavioural pipeline model
module tb_hazard_ctrl;

    localparam int DRAIN = 4;
    localparam int CW    = 32;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          instr_valid_d = 0, uses_rs_d = 0, uses_rt_d = 0, reg_write_d = 0;
    logic          halt_d = 0, redirect_m = 0;
    logic [4:0]    rs_addr_d = 0, rt_addr_d = 0, dst_addr_d = 0;
    logic          stall_f, stall_d, bubble_e, flush, halt_done;
    logic [1:0]    state;
    logic [CW-1:0] stall_cnt, flush_cnt;

    hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .instr_valid_d(instr_valid_d), .rs_addr_d(rs_addr_d), .rt_addr_d(rt_addr_d),
        .uses_rs_d(uses_rs_d), .uses_rt_d(uses_rt_d), .dst_addr_d(dst_addr_d),
        .reg_write_d(reg_write_d), .halt_d(halt_d), .redirect_m(redirect_m),
        .stall_f(stall_f), .stall_d(stall_d), .bubble_e(bubble_e), .flush(flush),
        .halt_done(halt_done), .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: destinations of the instructions now in EX and MEM (-1 = none),
    // run mode (0 run, 1 draining, 2 halted), drain cycles still to go.
    int          m_ex, m_mem, m_mode, m_left;
    logic [CW-1:0] m_stall_cnt, m_flush_cnt;
    bit          e_stall, e_flush, e_raw;

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_flight(input int a);
        return a != 0 && (a == m_ex || a == m_mem);
    endfunction

    task automatic model_reset();
        m_ex = -1; m_mem = -1; m_mode = 0; m_left = 0;
        m_stall_cnt = '0; m_flush_cnt = '0;
    endtask

    task automatic predict();
        e_raw = instr_valid_d && ((uses_rs_d && in_flight(int'(rs_addr_d))) ||
                                  (uses_rt_d && in_flight(int'(rt_addr_d))));
        case (m_mode)
            0:       begin e_flush = redirect_m; e_stall = e_raw && !redirect_m; end
            1:       begin e_flush = redirect_m; e_stall = 1'b1; end
            default: begin e_flush = 1'b0;       e_stall = 1'b1; end
        endcase
    endtask

    task automatic check_now(input string tag);
        predict();
        chk({tag, ".stall_f"},  CW'(stall_f),   CW'(e_stall));
        chk({tag, ".stall_d"},  CW'(stall_d),   CW'(e_stall));
        chk({tag, ".bubble_e"}, CW'(bubble_e),  CW'(e_stall));
        chk({tag, ".flush"},    CW'(flush),     CW'(e_flush));
        chk({tag, ".halt_done"},CW'(halt_done), CW'(m_mode == 2));
        chk({tag, ".state"},    CW'(state),     CW'(m_mode));
        chk({tag, ".stall_cnt"},stall_cnt,      PERF ? m_stall_cnt : '0);
        chk({tag, ".flush_cnt"},flush_cnt,      PERF ? m_flush_cnt : '0);
    endtask

    task automatic advance();
        int entering;
        predict();
        @(posedge CLK);
        entering = (instr_valid_d && reg_write_d && dst_addr_d != 0 && !e_stall && !e_flush)
                   ? int'(dst_addr_d) : -1;
        if (e_flush) begin m_ex = -1; m_mem = -1; end
        else begin m_mem = m_ex; m_ex = entering; end
        if (m_mode == 0 && e_stall && m_stall_cnt != '1) m_stall_cnt++;
        if (e_flush && m_flush_cnt != '1) m_flush_cnt++;
        case (m_mode)
            0: if (halt_d && instr_valid_d && !e_raw && !redirect_m) begin m_mode = 1; m_left = DRAIN; end
            1: if (redirect_m) m_mode = 0;
               else begin m_left--; if (m_left == 0) m_mode = 2; end
            default: ;
        endcase
        @(negedge CLK);
    endtask

    task automatic cycle(input string tag);
        #1;
        check_now(tag);
        advance();
    endtask

    task automatic set_in(input bit iv, input int rs, input int rt, input bit urs, input bit urt,
                          input int dst, input bit rw, input bit hlt, input bit redir);
        instr_valid_d = iv; rs_addr_d = 5'(rs); rt_addr_d = 5'(rt);
        uses_rs_d = urs; uses_rt_d = urt; dst_addr_d = 5'(dst);
        reg_write_d = rw; halt_d = hlt; redirect_m = redir;
    endtask

    task automatic do_reset(input string tag);
        RST_N = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #1;
        check_now(tag);
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset("reset");

        // addi $1 then an rs reader of $1: two stalls, clear on the third.
        set_in(1, 0, 0, 1, 0, 1, 1, 0, 0); cycle("addi");
        set_in(1, 1, 0, 1, 0, 2, 1, 0, 0);
        cycle("dep1_a"); cycle("dep1_b"); cycle("dep1_c");
        chk("dep1_stall_total", stall_cnt, PERF ? CW'(2) : '0);

        // Producer two ahead -> one stall; three ahead -> none.
        do_reset("r2");
        set_in(1, 0, 0, 0, 0, 5, 1, 0, 0); cycle("p5");
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0); cycle("fill");
        set_in(1, 0, 5, 0, 1, 6, 1, 0, 0); cycle("dep2_a"); cycle("dep2_b");
        set_in(1, 0, 0, 0, 0, 7, 1, 0, 0); cycle("p7");
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0); cycle("fill1"); cycle("fill2");
        set_in(1, 7, 0, 1, 0, 8, 1, 0, 0); cycle("dep3");

        // Writes to $0 and non-writing stores never create hazards.
        set_in(1, 0, 0, 0, 0, 0, 1, 0, 0); cycle("w0");
        set_in(1, 0, 0, 1, 1, 9, 1, 0, 0); cycle("r0");
        set_in(1, 0, 0, 0, 0, 10, 0, 0, 0); cycle("sw");
        set_in(1, 0, 10, 0, 1, 11, 1, 0, 0); cycle("rd_sw");

        // raw coinciding with redirect: flush wins, slots cleared.
        do_reset("r3");
        set_in(1, 0, 0, 0, 0, 3, 1, 0, 0); cycle("p3");
        set_in(1, 3, 0, 1, 0, 4, 1, 0, 1); cycle("raw_redir");
        set_in(1, 3, 0, 1, 0, 4, 1, 0, 0); cycle("after_flush");
        chk("flush_total", flush_cnt, PERF ? CW'(1) : '0);

        // Halt: 4 drain cycles, then halted for 20 cycles.
        do_reset("r4");
        set_in(1, 31, 31, 0, 0, 0, 0, 1, 0);
        cycle("halt_acc");
        for (int i = 0; i < DRAIN; i++) cycle("drain");
        for (int i = 0; i < 20; i++) cycle("halted");
        chk("halt_done_held", CW'(halt_done), CW'(1));
        set_in(1, 31, 31, 0, 0, 0, 0, 1, 1); cycle("halted_redir");

        // Redirect in the 2nd drain cycle returns to RUN.
        do_reset("r5");
        set_in(1, 31, 31, 0, 0, 0, 0, 1, 0); cycle("halt_acc2"); cycle("drain1");
        set_in(1, 31, 31, 0, 0, 0, 0, 1, 1); cycle("drain2_redir");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); cycle("back_run");
        chk("no_halt_done", CW'(halt_done), CW'(0));

        // Reset asserted in the 2nd drain cycle.
        do_reset("r6");
        set_in(1, 31, 31, 0, 0, 0, 0, 1, 0); cycle("halt_acc3"); cycle("drain1b");
        do_reset("mid_drain_reset");

        // Halt behind a hazard, and halt with redirect.
        set_in(1, 0, 0, 0, 0, 4, 1, 0, 0); cycle("p4");
        set_in(1, 4, 31, 1, 0, 0, 0, 1, 0); cycle("halt_raw_a"); cycle("halt_raw_b");
        cycle("halt_raw_acc"); cycle("halt_raw_drain");
        do_reset("r7");
        set_in(1, 31, 31, 0, 0, 0, 0, 1, 1); cycle("halt_redir"); cycle("halt_redir2");

        // Randomized traffic.
        do_reset("r8");
        for (int i = 0; i < 400; i++) begin
            if (m_mode == 2 && $urandom_range(0, 3) == 0) do_reset("rnd_reset");
            set_in($urandom_range(0, 4) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
                   $urandom_range(0, 1), $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
            cycle("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
